// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: A/D channel structs and opcode constants used by
// the TL-UL host and its devices.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  // Host to device: A channel plus d_ready
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  // Device to host: D channel plus a_ready
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_tlul_host.sv
// TL-UL host: turns a command stream (write / read / wait) into single-beat
// PutFullData and Get transactions, one in flight, with a response watchdog.
//
// Handshakes: a command transfers on the cycle where cmd_valid_i & cmd_ready_o
// are both high; the A channel transfers when a_valid & a_ready, the D channel
// when d_valid & d_ready. rsp_valid_o is a one-cycle strobe with no backpressure.
module student_tlul_host
  import tlul_pkg::*;
#(
  parameter logic [7:0]  SourceId      = 8'd0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_A_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RSP    = 3'd4
  } state_e;

  localparam logic [1:0]  OpWrite      = 2'd0;
  localparam logic [1:0]  OpRead       = 2'd1;
  localparam logic [1:0]  OpWait       = 2'd2;
  localparam logic [31:0] TimeoutLimit = 32'(TimeoutCycles);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;

  logic        wd_expire;
  logic        d_rsp_err;
  logic [2:0]  d_exp_opcode;
  logic        unused_tl_i;

  // Watchdog fires on the last allowed cycle of A_REQ+D_WAIT; >= keeps it
  // firing if a late a_ready carried the count past the limit.
  assign wd_expire = (TimeoutCycles != 0) && ((wd_cnt_q + 32'd1) >= TimeoutLimit);

  assign d_exp_opcode = (op_q == OpWrite) ? AccessAck : AccessAckData;
  assign d_rsp_err    = tl_i.d_error || (tl_i.d_source != SourceId) ||
                        (tl_i.d_opcode != d_exp_opcode);

  // D-channel fields the host does not interpret.
  assign unused_tl_i = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

  // State and datapath registers; reset aborts any command without a response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wait_cnt_q <= 32'd0;
      wd_cnt_q   <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic: command decode, bus sequencing, wait counting, watchdog.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d      = cmd_op_i;
          addr_d    = cmd_addr_i;
          wdata_d   = cmd_wdata_i;
          err_d     = 1'b0;
          timeout_d = 1'b0;
          case (cmd_op_i)
            OpWrite, OpRead: begin
              if (cmd_addr_i[1:0] != 2'd0) begin
                state_d = ST_RSP;
                err_d   = 1'b1;
                rdata_d = 32'd0;
              end else begin
                state_d  = ST_A_REQ;
                wd_cnt_d = 32'd0;
              end
            end
            OpWait: begin
              if (cmd_wdata_i == 32'd0) begin
                state_d = ST_RSP;
                rdata_d = 32'd0;
              end else begin
                state_d    = ST_WAIT;
                wait_cnt_d = cmd_wdata_i;
              end
            end
            default: begin
              state_d = ST_RSP;
              err_d   = 1'b1;
              rdata_d = 32'd0;
            end
          endcase
        end
      end
      ST_A_REQ: begin
        wd_cnt_d = wd_cnt_q + 32'd1;
        if (tl_i.a_ready) begin
          state_d = ST_D_WAIT;
        end else if (wd_expire) begin
          state_d   = ST_RSP;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          rdata_d   = 32'd0;
        end
      end
      ST_D_WAIT: begin
        wd_cnt_d = wd_cnt_q + 32'd1;
        if (tl_i.d_valid) begin
          state_d = ST_RSP;
          err_d   = d_rsp_err;
          rdata_d = (op_q == OpRead) ? tl_i.d_data : 32'd0;
        end else if (wd_expire) begin
          state_d   = ST_RSP;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          rdata_d   = 32'd0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 32'd1) begin
          state_d = ST_RSP;
          rdata_d = 32'd0;
        end else begin
          wait_cnt_d = wait_cnt_q - 32'd1;
        end
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign rsp_valid_o   = (state_q == ST_RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = rsp_valid_o && err_q;
  assign rsp_timeout_o = rsp_valid_o && timeout_q;

  // A-channel drive: fields are zero unless a request is being offered, and
  // d_ready stays high outside A_REQ/RSP so stray late responses are drained.
  always_comb begin
    tl_o         = '0;
    tl_o.d_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT) ||
                   (state_q == ST_D_WAIT);
    if (state_q == ST_A_REQ) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = (op_q == OpWrite) ? PutFullData : Get;
      tl_o.a_param   = 3'd0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = SourceId;
      tl_o.a_address = addr_q;
      tl_o.a_mask    = 4'hF;
      tl_o.a_data    = (op_q == OpWrite) ? wdata_q : 32'd0;
      tl_o.a_user    = TL_A_USER_DEFAULT;
    end
  end

endmodule

// File: tb/tb_student_tlul_host.sv
// Testbench for student_tlul_host: a small register-device responder, a
// per-negedge sampler, and a response scoreboard fed when commands are accepted.
module tb_student_tlul_host;
  import tlul_pkg::*;

  localparam logic [7:0]  SRC = 8'h05;
  localparam int unsigned TO  = 16;
  localparam logic [1:0]  OP_W = 2'd0, OP_R = 2'd1, OP_WAIT = 2'd2, OP_RSV = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  tl_h2d_t     tl_h2d;
  tl_d2h_t     tl_d2h;

  student_tlul_host #(.SourceId(SRC), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .tl_o(tl_h2d), .tl_i(tl_d2h)
  );

  // ---------------- device model ----------------
  logic        dev_stall, dev_derr, dev_bad_op;
  logic [7:0]  dev_src_off;
  int          inj_req = 0;
  int          inj_done = 0;
  logic        dv = 1'b0;
  logic [2:0]  dop = 3'd0;
  logic [7:0]  dsrc = 8'd0;
  logic        derr = 1'b0;
  logic [31:0] ddata = 32'd0;
  logic [31:0] mem [16] = '{default: 32'd0};

  always_comb begin
    tl_d2h          = '0;
    tl_d2h.a_ready  = ~dev_stall;
    tl_d2h.d_valid  = dv;
    tl_d2h.d_opcode = dop;
    tl_d2h.d_source = dsrc;
    tl_d2h.d_error  = derr;
    tl_d2h.d_data   = ddata;
  end

  // Zero-stall register device; can also inject an unsolicited late response.
  always @(posedge clk) begin
    if (dv && tl_h2d.d_ready) dv <= 1'b0;
    if (tl_h2d.a_valid && !dev_stall) begin
      dv   <= 1'b1;
      dsrc <= tl_h2d.a_source + dev_src_off;
      derr <= dev_derr;
      if (tl_h2d.a_opcode == Get) begin
        dop   <= dev_bad_op ? AccessAck : AccessAckData;
        ddata <= mem[tl_h2d.a_address[5:2]];
      end else begin
        dop   <= dev_bad_op ? AccessAckData : AccessAck;
        ddata <= 32'd0;
        mem[tl_h2d.a_address[5:2]] <= tl_h2d.a_data;
      end
    end else if (inj_req != inj_done) begin
      dv       <= 1'b1;
      dop      <= AccessAckData;
      dsrc     <= SRC;
      derr     <= 1'b0;
      ddata    <= 32'hDEAD_BEEF;
      inj_done <= inj_done + 1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];   // {timeout, err, rdata}
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_rsp_cyc = 0;
  int rsp_cnt = 0;
  int av_cnt = 0;
  int busy_cnt = 0;
  tl_h2d_t last_a = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [33:0] ex(input logic to, input logic er, input logic [31:0] d);
    return {to, er, d};
  endfunction

  task automatic sample();
    logic [33:0] e;
    if (tl_h2d.a_valid) begin
      av_cnt++;
      last_a = tl_h2d;
    end
    if (busy) busy_cnt++;
    if (!rsp_valid && (rsp_err || rsp_timeout))
      chk("err_gating", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    if (rsp_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e[33]});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [33:0] e);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    end else begin
      acc_cyc = cyc;
      exp_q.push_back(e);
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int guard = 0;
    while (rsp_cnt < target && guard < 200) begin
      tick();
      guard++;
    end
    chk("rsp_arrived", 32'(rsp_cnt), 32'(target));
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [33:0] e, input int lat);
    int target;
    target = rsp_cnt + 1;
    send_cmd(op, addr, wdata, e);
    wait_rsp(target);
    chk("latency", 32'(last_rsp_cyc - acc_cyc), 32'(lat));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, " rsp_timeout"}, {31'd0, rsp_timeout}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " a_valid"}, {31'd0, tl_h2d.a_valid}, 32'd0);
    chk({tag, " a_opcode_size_mask"}, {23'd0, tl_h2d.a_opcode, tl_h2d.a_size, tl_h2d.a_mask},
        32'd0);
    chk({tag, " a_address"}, tl_h2d.a_address, 32'd0);
    chk({tag, " a_data"}, tl_h2d.a_data, 32'd0);
    chk({tag, " d_ready"}, {31'd0, tl_h2d.d_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int av0, b0, a1, n0, target;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    dev_stall = 1'b0; dev_derr = 1'b0; dev_bad_op = 1'b0; dev_src_off = 8'd0;
    tick(); tick();
    check_reset_vals("rst_hold");
    rst = 1'b0;
    tick();
    check_reset_vals("rst_release");

    // Register write then read-back
    do_cmd(OP_W, 32'h8, 32'hFFFF_FF42, ex(1'b0, 1'b0, 32'd0), 3);
    do_cmd(OP_R, 32'h8, 32'd0, ex(1'b0, 1'b0, 32'hFFFF_FF42), 3);
    chk("rlight_byte", {24'd0, rsp_rdata[7:0]}, 32'h42);

    // Zero-stall write: one A beat with PutFullData fields
    av0 = av_cnt;
    do_cmd(OP_W, 32'h4, 32'h1234_5678, ex(1'b0, 1'b0, 32'd0), 3);
    chk("write_a_beats", 32'(av_cnt - av0), 32'd1);
    chk("write_a_opcode", {29'd0, last_a.a_opcode}, 32'd0);
    chk("write_a_mask", {28'd0, last_a.a_mask}, 32'hF);
    chk("write_a_size", {30'd0, last_a.a_size}, 32'd2);
    chk("write_a_addr", last_a.a_address, 32'h4);
    chk("write_a_data", last_a.a_data, 32'h1234_5678);
    chk("write_a_source", {24'd0, last_a.a_source}, {24'd0, SRC});
    chk("write_a_param", {29'd0, last_a.a_param}, 32'd0);
    do_cmd(OP_R, 32'h4, 32'hAAAA_AAAA, ex(1'b0, 1'b0, 32'h1234_5678), 3);
    chk("read_a_opcode", {29'd0, last_a.a_opcode}, 32'd4);
    chk("read_a_data", last_a.a_data, 32'd0);

    // Misaligned read and reserved op: error, no bus access, 1-cycle latency
    av0 = av_cnt;
    do_cmd(OP_R, 32'h6, 32'd0, ex(1'b0, 1'b1, 32'd0), 1);
    do_cmd(OP_W, 32'h9, 32'h5, ex(1'b0, 1'b1, 32'd0), 1);
    do_cmd(OP_RSV, 32'h0, 32'd0, ex(1'b0, 1'b1, 32'd0), 1);
    chk("no_bus_on_err", 32'(av_cnt - av0), 32'd0);

    // Wait commands
    av0 = av_cnt;
    b0 = busy_cnt;
    do_cmd(OP_WAIT, 32'd0, 32'd5, ex(1'b0, 1'b0, 32'd0), 6);
    chk("wait5_busy", 32'(busy_cnt - b0), 32'd6);
    tick();
    chk("wait5_idle", {31'd0, busy}, 32'd0);
    do_cmd(OP_WAIT, 32'd0, 32'd0, ex(1'b0, 1'b0, 32'd0), 1);
    do_cmd(OP_WAIT, 32'd0, 32'd1, ex(1'b0, 1'b0, 32'd0), 2);
    chk("wait_no_bus", 32'(av_cnt - av0), 32'd0);

    // Back-to-back writes: 4-cycle command period
    target = rsp_cnt + 2;
    send_cmd(OP_W, 32'h20, 32'hCAFE_0001, ex(1'b0, 1'b0, 32'd0));
    a1 = acc_cyc;
    send_cmd(OP_W, 32'h24, 32'hCAFE_0002, ex(1'b0, 1'b0, 32'd0));
    chk("b2b_period", 32'(acc_cyc - a1), 32'd4);
    wait_rsp(target);
    do_cmd(OP_R, 32'h24, 32'd0, ex(1'b0, 1'b0, 32'hCAFE_0002), 3);

    // Watchdog: device never accepts
    dev_stall = 1'b1;
    av0 = av_cnt;
    do_cmd(OP_R, 32'hC, 32'd0, ex(1'b1, 1'b1, 32'd0), TO + 1);
    chk("timeout_a_beats", 32'(av_cnt - av0), 32'(TO));
    chk("timeout_a_dropped", {31'd0, tl_h2d.a_valid}, 32'd0);
    dev_stall = 1'b0;
    n0 = rsp_cnt;
    inj_req++;
    tick(); tick(); tick(); tick();
    chk("late_d_absorbed", 32'(rsp_cnt), 32'(n0));
    do_cmd(OP_R, 32'h8, 32'd0, ex(1'b0, 1'b0, 32'hFFFF_FF42), 3);

    // Error responses from the device
    dev_derr = 1'b1;
    do_cmd(OP_W, 32'h10, 32'd1, ex(1'b0, 1'b1, 32'd0), 3);
    dev_derr = 1'b0;
    dev_src_off = 8'd1;
    do_cmd(OP_W, 32'h10, 32'd2, ex(1'b0, 1'b1, 32'd0), 3);
    dev_src_off = 8'd0;
    dev_bad_op = 1'b1;
    do_cmd(OP_W, 32'h10, 32'd3, ex(1'b0, 1'b1, 32'd0), 3);
    dev_bad_op = 1'b0;

    // Reset in the middle of A_REQ
    do_cmd(OP_R, 32'h8, 32'd0, ex(1'b0, 1'b0, 32'hFFFF_FF42), 3);
    dev_stall = 1'b1;
    send_cmd(OP_R, 32'h8, 32'd0, ex(1'b0, 1'b0, 32'd0));
    chk("areq_before_rst", {31'd0, tl_h2d.a_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    exp_q.delete();
    n0 = rsp_cnt;
    tick();
    rst = 1'b0;
    dev_stall = 1'b0;
    tick(); tick();
    chk("rst_no_rsp", 32'(rsp_cnt), 32'(n0));
    do_cmd(OP_R, 32'h8, 32'd0, ex(1'b0, 1'b0, 32'hFFFF_FF42), 3);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
